// File: rtl/rot_sigma_pipe_if.sv
// Handshake bundle for the shared rotate/shift/sigma unit: input word
// channel and result channel, both valid/ready.
interface rot_sigma_pipe_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rot_sigma_pipe.sv
// Shared two-stage rotate/shift/SHA-256 sigma unit with elastic valid/ready
// pipeline; stage 1 forms up to three rotated terms, stage 2 XORs them.
module rot_sigma_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AMT_W = 5,
  parameter int unsigned TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  rot_sigma_pipe_if.slave bus
);

  // SHA-256 rotate/shift constants, folded into the word width
  localparam int unsigned S0_A = 7  % WIDTH;
  localparam int unsigned S0_B = 18 % WIDTH;
  localparam int unsigned S0_C = 3  % WIDTH;
  localparam int unsigned S1_A = 17 % WIDTH;
  localparam int unsigned S1_B = 19 % WIDTH;
  localparam int unsigned S1_C = 10 % WIDTH;
  localparam int unsigned B0_A = 2  % WIDTH;
  localparam int unsigned B0_B = 13 % WIDTH;
  localparam int unsigned B0_C = 22 % WIDTH;
  localparam int unsigned B1_A = 6  % WIDTH;
  localparam int unsigned B1_B = 11 % WIDTH;
  localparam int unsigned B1_C = 25 % WIDTH;

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                            input int unsigned      n);
    int unsigned k;
    k = n % WIDTH;
    if (k == 0) return x;
    return (x >> k) | (x << (WIDTH - k));
  endfunction

  logic [WIDTH-1:0] t0, t1, t2;
  logic [WIDTH-1:0] s1_t0, s1_t1, s1_t2;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_valid;
  logic             adv1, adv2;
  int unsigned      amt;

  assign amt  = 32'(bus.in_amt);
  assign adv2 = !bus.out_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;
  assign bus.in_ready = adv1;

  // Stage-1 term generation; single-term ops leave t1/t2 at zero
  always_comb begin
    t0 = bus.in_data;
    t1 = '0;
    t2 = '0;
    case (bus.in_op)
      3'd0: t0 = rotr(bus.in_data, amt);
      3'd1: t0 = rotr(bus.in_data, (WIDTH - (amt % WIDTH)));
      3'd2: t0 = bus.in_data >> bus.in_amt;
      3'd3: begin
        t0 = rotr(bus.in_data, S0_A);
        t1 = rotr(bus.in_data, S0_B);
        t2 = bus.in_data >> S0_C;
      end
      3'd4: begin
        t0 = rotr(bus.in_data, S1_A);
        t1 = rotr(bus.in_data, S1_B);
        t2 = bus.in_data >> S1_C;
      end
      3'd5: begin
        t0 = rotr(bus.in_data, B0_A);
        t1 = rotr(bus.in_data, B0_B);
        t2 = rotr(bus.in_data, B0_C);
      end
      3'd6: begin
        t0 = rotr(bus.in_data, B1_A);
        t1 = rotr(bus.in_data, B1_B);
        t2 = rotr(bus.in_data, B1_C);
      end
      default: ;
    endcase
  end

  // Pipeline registers; each stage loads only when it can hand its word on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_t0         <= '0;
      s1_t1         <= '0;
      s1_t2         <= '0;
      s1_tag        <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_tag   <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_t0  <= t0;
          s1_t1  <= t1;
          s1_t2  <= t2;
          s1_tag <= bus.in_tag;
        end
      end
      if (adv2) begin
        bus.out_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_data <= s1_t0 ^ s1_t1 ^ s1_t2;
          bus.out_tag  <= s1_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_rot_sigma_pipe.sv
// Self-checking bench for rot_sigma_pipe: directed vectors plus randomized
// streaming/backpressure against a bit-level reference model.
module tb_rot_sigma_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  exp_t q[$];

  rot_sigma_pipe_if #(.WIDTH(32), .AMT_W(5), .TAG_W(4)) bus ();

  rot_sigma_pipe #(.WIDTH(32), .AMT_W(5), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: result bit i of ROTR(x,n) is input bit (i+n) mod 32
  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[(i + n) % 32];
    return r;
  endfunction

  function automatic logic [31:0] m_op(input logic [2:0] op, input logic [31:0] x,
                                       input int n);
    case (op)
      3'd0: return m_rotr(x, n);
      3'd1: return m_rotr(x, 32 - n);
      3'd2: return 32'(x / (64'd1 << n));
      3'd3: return m_rotr(x, 7) ^ m_rotr(x, 18) ^ (x / 32'd8);
      3'd4: return m_rotr(x, 17) ^ m_rotr(x, 19) ^ (x / 32'd1024);
      3'd5: return m_rotr(x, 2) ^ m_rotr(x, 13) ^ m_rotr(x, 22);
      3'd6: return m_rotr(x, 6) ^ m_rotr(x, 11) ^ m_rotr(x, 25);
      default: return x;
    endcase
  endfunction

  task automatic drive_random(input int tag);
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.in_amt   = 5'($urandom_range(31));
    bus.in_op    = 3'($urandom_range(7));
    bus.in_tag   = 4'(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEADBEEF;
    bus.in_amt = 5'd3;
    bus.in_op = 3'd0;
    bus.in_tag = 4'hA;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else passed++;
    checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", bus.out_data); else passed++;
    checks++; if (bus.out_tag !== 4'h0) $display("FAIL reset_out_tag got %h want 0", bus.out_tag); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_no_output cyc %0d got %b want 0", c, bus.out_valid); else passed++;
    end
  endtask

  task automatic test_basic_ops();
    logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd0, 3'd4};
    logic [31:0] xs  [8] = '{32'h00000001, 32'h80000001, 32'hF0000000, 32'h00000001,
                             32'h00000001, 32'h00000001, 32'h00000001, 32'h00000001};
    logic [4:0]  ns  [8] = '{5'd4, 5'd1, 5'd28, 5'd9, 5'd9, 5'd9, 5'd0, 5'd31};
    logic [31:0] es  [8] = '{32'h10000000, 32'h00000003, 32'h0000000F, 32'h02004000,
                             32'h04200080, 32'h00000001, 32'h00000001, 32'h0000A000};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data = xs[i];
      bus.in_amt = ns[i];
      bus.in_op = ops[i];
      bus.in_tag = 4'(i + 3);
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b1) $display("FAIL basic%0d_in_ready got %b want 1", i, bus.in_ready); else passed++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic%0d_early got out_valid %b want 0", i, bus.out_valid); else passed++;
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) $display("FAIL basic%0d_valid got %b want 1", i, bus.out_valid); else passed++;
      checks++; if (bus.out_data !== es[i]) $display("FAIL basic%0d_data op%0d got %h want %h", i, ops[i], bus.out_data, es[i]); else passed++;
      checks++; if (bus.out_tag !== 4'(i + 3)) $display("FAIL basic%0d_tag got %h want %h", i, bus.out_tag, 4'(i + 3)); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int got = 0, first = -1, last = -1;
    exp_t e;
    q.delete();
    for (int cyc = 0; cyc < 30 && got < 16; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      if (cyc < 16) drive_random(cyc); else bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.in_valid) begin
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready cyc %0d got %b want 1", cyc, bus.in_ready); else passed++;
      end
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        if (q.size() == 0) begin
          checks++; $display("FAIL stream_extra output %h with no pending word", bus.out_data);
        end else begin
          e = q.pop_front();
          checks++; if (bus.out_data !== e.d || bus.out_tag !== e.t) $display("FAIL stream_word got %h/%h want %h/%h", bus.out_data, bus.out_tag, e.d, e.t); else passed++;
        end
      end
      if (bus.in_valid && bus.in_ready) q.push_back('{m_op(bus.in_op, bus.in_data, int'(bus.in_amt)), bus.in_tag});
    end
    bus.in_valid = 1'b0;
    checks++; if (got !== 16) $display("FAIL stream_count got %0d want 16", got); else passed++;
    checks++; if (last - first !== 15) $display("FAIL stream_consecutive span got %0d want 15", last - first); else passed++;
  endtask

  task automatic test_backpressure();
    int sent = 0, got = 0;
    logic acc = 1'b0, hold = 1'b0, exp_rdy;
    logic [31:0] hd;
    logic [3:0]  ht;
    exp_t e;
    q.delete();
    bus.in_valid = 1'b0;
    for (int cyc = 0; cyc < 800 && got < 40; cyc++) begin
      @(posedge clk); #1;
      if (acc) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < 40 && $urandom_range(3) != 0) drive_random(sent);
      bus.out_ready = 1'($urandom_range(1));
      @(negedge clk);
      if (hold) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== hd || bus.out_tag !== ht) $display("FAIL bp_hold got %b/%h/%h want 1/%h/%h", bus.out_valid, bus.out_data, bus.out_tag, hd, ht); else passed++;
      end
      exp_rdy = !(q.size() == 2 && !bus.out_ready);
      checks++; if (bus.in_ready !== exp_rdy) $display("FAIL bp_in_ready cyc %0d got %b want %b (occupancy %0d)", cyc, bus.in_ready, exp_rdy, q.size()); else passed++;
      if (bus.out_valid && bus.out_ready) begin
        got++;
        if (q.size() == 0) begin
          checks++; $display("FAIL bp_extra output %h with no pending word", bus.out_data);
        end else begin
          e = q.pop_front();
          checks++; if (bus.out_data !== e.d || bus.out_tag !== e.t) $display("FAIL bp_word got %h/%h want %h/%h", bus.out_data, bus.out_tag, e.d, e.t); else passed++;
        end
      end
      hold = bus.out_valid && !bus.out_ready;
      hd = bus.out_data;
      ht = bus.out_tag;
      acc = bus.in_valid && bus.in_ready;
      if (acc) begin
        q.push_back('{m_op(bus.in_op, bus.in_data, int'(bus.in_amt)), bus.in_tag});
        sent++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    checks++; if (got !== 40) $display("FAIL bp_count got %0d want 40", got); else passed++;
    checks++; if (q.size() !== 0) $display("FAIL bp_leftover got %0d want 0", q.size()); else passed++;
  endtask

  task automatic test_reset_mid_stream();
    logic [31:0] exp_d;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    drive_random(1);
    @(posedge clk); #1;
    drive_random(2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL midrst_full got valid %b ready %b want 1 0", bus.out_valid, bus.in_ready); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) $display("FAIL midrst_flush got %b/%h want 0/0", bus.out_valid, bus.out_data); else passed++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", bus.in_ready); else passed++;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h12345678;
    bus.in_amt = 5'd8;
    bus.in_op = 3'd1;
    bus.in_tag = 4'h9;
    exp_d = m_op(3'd1, 32'h12345678, 8);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_stale got out_valid %b want 0", bus.out_valid); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_tag !== 4'h9) $display("FAIL midrst_word got %b/%h/%h want 1/%h/9", bus.out_valid, bus.out_data, bus.out_tag, exp_d); else passed++;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_dup got out_valid %b want 0", bus.out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
